// File: rtl/stream_aligner.sv
// Bit-slip word aligner with a sync-header lock FSM.
// Define STREAM_ALIGNER_STATS_EN for the bad-header and lock-loss counters.
module stream_aligner #(
  parameter int DATA_WIDTH = 80,
  parameter int OFFSET_W   = $clog2(DATA_WIDTH),
  parameter int LOCK_CNT   = 64,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 16,
  parameter int SLIP_WAIT  = 2
) (
  input  logic                  USER_CLK,
  input  logic                  RESET_N,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic [DATA_WIDTH-1:0] MASK,
  input  logic                  MANUAL_EN,
  input  logic [OFFSET_W-1:0]   OFFSET_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_VALID,
  output logic                  LOCKED,
  output logic [OFFSET_W-1:0]   OFFSET_OUT
`ifdef STREAM_ALIGNER_STATS_EN
  ,
  input  logic                  STATS_CLR,
  output logic [15:0]           BAD_HDR_CNT,
  output logic [7:0]            LOCK_LOSS_CNT
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam int BW = $clog2(SLIP_WAIT + 2);

  localparam logic [OFFSET_W-1:0] OFF_MAX = OFFSET_W'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
  localparam logic [EW-1:0] BAD_LAST  = EW'(ERR_THRESH - 1);

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]   raw_r;
  logic [2*DATA_WIDTH-1:0] cat;
  logic [DATA_WIDTH-1:0]   aligned;
  logic [1:0]              hdr;

  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [OFFSET_W-1:0] man_off, slip_off;
  logic [BW-1:0]       blank_q, blank_d;
  logic [GW-1:0]       good_q, good_d;
  logic [WW-1:0]       win_q, win_d;
  logic [EW-1:0]       bad_q, bad_d;

  logic hdr_ok, man_chg, check;
  logic hunt_chk, lock_chk;
  logic bad_hit, lose_lock, slip;

  assign aligned  = DATA_WIDTH'(cat >> offset_q);
  assign hdr_ok   = hdr[1] ^ hdr[0];
  assign man_off  = (OFFSET_IN >= OFF_MAX) ? OFF_MAX : OFFSET_IN;
  assign slip_off = (offset_q == OFF_MAX) ? '0 : offset_q + 1'b1;

  // A manual offset change pre-empts judging the (stale) header that cycle
  assign man_chg  = MANUAL_EN && (man_off != offset_q);
  assign check    = !man_chg && (blank_q == '0);
  assign hunt_chk = check && (state_q == S_HUNT);
  assign lock_chk = check && (state_q == S_LOCKED);

  assign bad_hit   = lock_chk && !hdr_ok;
  assign lose_lock = (state_q == S_LOCKED) &&
                     (man_chg || (bad_hit && (bad_q == BAD_LAST)));

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    blank_d  = blank_q;
    good_d   = good_q;
    win_d    = win_q;
    bad_d    = bad_q;
    slip     = 1'b0;
    if (blank_q != '0) blank_d = blank_q - 1'b1;
    unique case (1'b1)
      man_chg: begin
        state_d  = S_HUNT;
        offset_d = man_off;
        blank_d  = BW'(SLIP_WAIT);
        good_d   = '0;
        win_d    = '0;
        bad_d    = '0;
      end
      hunt_chk: begin
        if (hdr_ok) begin
          good_d = good_q + 1'b1;
          if (good_q == GOOD_LAST) begin
            state_d = S_LOCKED;
            good_d  = '0;
            win_d   = '0;
            bad_d   = '0;
          end
        end else begin
          good_d = '0;
          slip   = !MANUAL_EN;
        end
      end
      lock_chk: begin
        win_d = win_q + 1'b1;
        bad_d = bad_q + EW'(bad_hit);
        if (lose_lock) begin
          state_d = S_HUNT;
          good_d  = '0;
          win_d   = '0;
          bad_d   = '0;
          slip    = !MANUAL_EN;
        end else if (win_q == WIN_LAST) begin
          win_d = '0;
          bad_d = '0;
        end
      end
      default: ;
    endcase
    if (slip) begin
      offset_d = slip_off;
      blank_d  = BW'(SLIP_WAIT);
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (!RESET_N) begin
      raw_r      <= '0;
      cat        <= '0;
      hdr        <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      state_q    <= S_HUNT;
      offset_q   <= '0;
      blank_q    <= '0;
      good_q     <= '0;
      win_q      <= '0;
      bad_q      <= '0;
    end else begin
      raw_r      <= DATA_IN;
      cat        <= {DATA_IN, raw_r};
      hdr        <= aligned[1:0];
      DATA_OUT   <= aligned ^ MASK;
      DATA_VALID <= (state_d == S_LOCKED) && (blank_d == '0);
      state_q    <= state_d;
      offset_q   <= offset_d;
      blank_q    <= blank_d;
      good_q     <= good_d;
      win_q      <= win_d;
      bad_q      <= bad_d;
    end
  end

  assign LOCKED     = (state_q == S_LOCKED);
  assign OFFSET_OUT = offset_q;

`ifdef STREAM_ALIGNER_STATS_EN
  always_ff @(posedge USER_CLK) begin
    if (!RESET_N || STATS_CLR) begin
      BAD_HDR_CNT   <= '0;
      LOCK_LOSS_CNT <= '0;
    end else begin
      if (bad_hit && (BAD_HDR_CNT != '1))
        BAD_HDR_CNT <= BAD_HDR_CNT + 16'd1;
      if (lose_lock && (LOCK_LOSS_CNT != '1))
        LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: doc/stream_aligner.md
Name: stream_aligner

Overview:
- Parametrised word aligner placed after the transceiver RX interface, ahead of descrambling and framing.
- Each cycle it concatenates two consecutive raw words, barrel-shifts by a bit offset and XORs the result with a mask.
- A sync-header lock FSM searches the offset automatically, slipping one bit per trial until a stable header position is found.
- Reports lock state and the current offset; a manual-offset override is provided for bring-up.

Parameters:
- DATA_WIDTH, 80, raw and aligned word width in bits; must be >= 3.
- OFFSET_W, $clog2(DATA_WIDTH), width of offset ports and registers.
- LOCK_CNT, 64, consecutive valid headers needed to declare lock.
- WINDOW, 64, header-check window length while locked.
- ERR_THRESH, 16, invalid headers within one window that force loss of lock.
- SLIP_WAIT, 2, blanking cycles after each offset change before headers are judged.

Ports:
- USER_CLK  in  1  clock for all logic.
- RESET_N  in  1  synchronous, active-low reset.
- DATA_IN  in  DATA_WIDTH  raw word; bit 0 is the earliest bit.
- MASK  in  DATA_WIDTH  XOR mask applied to the aligned word.
- MANUAL_EN  in  1  1 = use OFFSET_IN; automatic slipping is suppressed.
- OFFSET_IN  in  OFFSET_W  manual offset, 0..DATA_WIDTH-1.
- DATA_OUT  out  DATA_WIDTH  aligned word XOR MASK.
- DATA_VALID  out  1  DATA_OUT is aligned (LOCKED and not blanking).
- LOCKED  out  1  FSM is in the LOCKED state.
- OFFSET_OUT  out  OFFSET_W  offset currently applied.

Behaviour:
- Reset (RESET_N=0 at an edge):
  - DATA_OUT=0, DATA_VALID=0, LOCKED=0, OFFSET_OUT=0.
  - Pipeline registers cleared, all counters 0, state HUNT.
  - Reset takes priority over every other event, including mid-slip or mid-window.
- Pipeline:
  - Stage 1 registers raw_r <= DATA_IN and cat <= {DATA_IN, raw_r}.
  - Stage 2 computes sh = cat >> offset, then DATA_OUT <= sh[DATA_WIDTH-1:0] ^ MASK and hdr <= sh[1:0].
  - Latency from DATA_IN to DATA_OUT is 2 cycles.
  - An offset change at edge t takes effect in DATA_OUT at edge t+1.
- Header check:
  - Uses hdr, the pre-mask value; MASK never affects locking.
  - A header is valid iff hdr is 2'b01 or 2'b10.
  - No check is made while the blank counter is nonzero.
- Slip:
  - offset <= (offset == DATA_WIDTH-1) ? 0 : offset+1, so it wraps around.
  - The blank counter is loaded with SLIP_WAIT.
  - A MANUAL_EN=1 cycle in which OFFSET_IN differs from offset loads OFFSET_IN and also loads the blank counter.
  - OFFSET_IN >= DATA_WIDTH is clamped to DATA_WIDTH-1.
- States:
  - HUNT:
    - Valid header: good_cnt++.
    - good_cnt reaches LOCK_CNT: go to LOCKED, clear the window counters.
    - Invalid header: good_cnt=0, and slip unless MANUAL_EN=1.
  - LOCKED:
    - Every checked word increments win_cnt; every invalid word increments bad_cnt.
    - bad_cnt reaches ERR_THRESH before win_cnt reaches WINDOW: go to HUNT, good_cnt=0, slip unless MANUAL_EN=1.
    - win_cnt reaches WINDOW: clear win_cnt and bad_cnt, stay LOCKED.
    - If the last window word is also the ERR_THRESH-th error, loss of lock wins.
- MANUAL_EN:
  - 1→0 resumes automatic hunting from the current offset; the FSM state is kept.
  - 0→1 while LOCKED with OFFSET_IN==offset causes no disturbance.
  - An offset change while LOCKED forces HUNT.
- Output flags:
  - DATA_VALID = LOCKED & (blank counter == 0), registered so it is aligned with DATA_OUT.
  - LOCKED and OFFSET_OUT are registered.

Optional Feature:
- Macro: STREAM_ALIGNER_STATS_EN.
- Defined: adds output ports BAD_HDR_CNT [15:0] and LOCK_LOSS_CNT [7:0].
  - BAD_HDR_CNT counts invalid headers seen while LOCKED.
  - LOCK_LOSS_CNT counts LOCKED→HUNT transitions.
  - Both saturate at all-ones, clear on reset and clear on the input STATS_CLR (1 bit; clear has priority over increment in the same cycle).
- Undefined: none of these ports, counters or inputs exist; remaining behaviour is identical.

Test Plan:
1. Reset with RESET_N=0 for 3 cycles under random DATA_IN -> all outputs 0 and state HUNT; every cycle after release matches the reference model.
2. Scrambled 80-bit frames with a valid header at bit 13, MANUAL_EN=0 -> OFFSET_OUT settles at 13, LOCKED=1 after 64 good headers, DATA_OUT equals the model's payload ^ MASK, DATA_VALID=1.
3. Locked at 13, then inject 15 invalid headers in one 64-word window -> stays locked; 16 invalid -> LOCKED=0 on the 16th and slip to 14.
4. Header at bit 0 with hunting started from offset 79 -> wrap to 0 and lock, OFFSET_OUT=0.
5. MANUAL_EN=1, OFFSET_IN=13 on a correct stream -> lock with no slips; OFFSET_IN=90 -> clamped to 79 and LOCKED drops.
6. With STATS_EN: lock, inject 20 errors -> LOCK_LOSS_CNT=1 and BAD_HDR_CNT=16; STATS_CLR together with an error -> counters read 0.
